// File: rtl/serial2parallel_stream.sv
// Serial-to-parallel deserializer: assembles framed, qualified serial bits into
// DATA_W-bit words (LSB- or MSB-first) and presents them through a valid/ready
// output register that reports words dropped while it is full.
module serial2parallel_stream #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_start,
    input  logic              serial_in,
    input  logic              serial_valid,
    input  logic              abort,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              conversion_end,
    output logic              overflow,
    output logic              frame_restart,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [DATA_W-1:0] shifted_word;
    logic [DATA_W-1:0] first_word;
    logic              word_done;
    logic              restart;
    logic              out_free;
    logic              load_word;

    // Shift register with the current bit inserted, and a fresh register holding only the current bit
    always_comb begin
        shifted_word = '0;
        first_word   = '0;
        if (MSB_FIRST) begin
            shifted_word = {shift_reg[DATA_W-2:0], serial_in};
            first_word   = {{(DATA_W-1){1'b0}}, serial_in};
        end else begin
            shifted_word = {serial_in, shift_reg[DATA_W-1:1]};
            first_word   = {serial_in, {(DATA_W-1){1'b0}}};
        end
    end

    // Next-state logic: frame start, bit capture, restart, completion and abort
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        word_done    = 1'b0;
        restart      = 1'b0;
        if (abort) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            shift_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (serial_valid && serial_start) begin
                        shift_next   = first_word;
                        bit_cnt_next = CNT_W'(1);
                        state_next   = SHIFT;
                    end
                end
                SHIFT: begin
                    if (serial_valid) begin
                        if (serial_start) begin
                            restart      = 1'b1;
                            shift_next   = first_word;
                            bit_cnt_next = CNT_W'(1);
                        end else if (bit_cnt == LAST_BIT) begin
                            word_done    = 1'b1;
                            shift_next   = '0;
                            bit_cnt_next = '0;
                            state_next   = IDLE;
                        end else begin
                            shift_next   = shifted_word;
                            bit_cnt_next = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next   = IDLE;
                    bit_cnt_next = '0;
                    shift_next   = '0;
                end
            endcase
        end
    end

    // State, bit counter and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
        end
    end

    // The output register can take a new word if empty or being drained this cycle
    assign out_free  = !m_valid || m_ready;
    assign load_word = word_done && out_free;

    // Output register, handshake and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data         <= '0;
            m_valid        <= 1'b0;
            conversion_end <= 1'b0;
            overflow       <= 1'b0;
            frame_restart  <= 1'b0;
        end else begin
            if (load_word) begin
                m_data  <= shifted_word;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            conversion_end <= load_word;
            overflow       <= word_done && !out_free;
            frame_restart  <= restart;
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_serial2parallel_stream.sv
// Self-checking bench for serial2parallel_stream: three instances (8-bit LSB-first,
// 8-bit MSB-first sharing the same serial stream, 12-bit MSB-first) with a
// scoreboard of expected words per instance.
module tb_serial2parallel_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        serial_start;
    logic        serial_in;
    logic        serial_valid;
    logic        abort;
    logic        m_ready;
    logic        serial_start2;
    logic        serial_in2;
    logic        serial_valid2;
    logic        abort2;
    logic        m_ready2;

    logic [7:0]  m_data0;
    logic        m_valid0, cend0, ovf0, frs0, busy0;
    logic [7:0]  m_data1;
    logic        m_valid1, cend1, ovf1, frs1, busy1;
    logic [11:0] m_data2;
    logic        m_valid2, cend2, ovf2, frs2, busy2;

    int total = 0;
    int bad   = 0;
    int n_cend = 0;
    int n_ovf  = 0;
    int n_frs  = 0;
    int snap;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [31:0] exp2[$];

    always #5 clk = ~clk;

    serial2parallel_stream #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb8 (
        .clk(clk), .rst(rst), .serial_start(serial_start), .serial_in(serial_in),
        .serial_valid(serial_valid), .abort(abort), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready), .conversion_end(cend0), .overflow(ovf0),
        .frame_restart(frs0), .busy(busy0)
    );

    serial2parallel_stream #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb8 (
        .clk(clk), .rst(rst), .serial_start(serial_start), .serial_in(serial_in),
        .serial_valid(serial_valid), .abort(abort), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(m_ready), .conversion_end(cend1), .overflow(ovf1),
        .frame_restart(frs1), .busy(busy1)
    );

    serial2parallel_stream #(.DATA_W(12), .MSB_FIRST(1'b1)) u_msb12 (
        .clk(clk), .rst(rst), .serial_start(serial_start2), .serial_in(serial_in2),
        .serial_valid(serial_valid2), .abort(abort2), .m_data(m_data2), .m_valid(m_valid2),
        .m_ready(m_ready2), .conversion_end(cend2), .overflow(ovf2),
        .frame_restart(frs2), .busy(busy2)
    );

    // Count a comparison and report it if the observed value differs
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of the shared 8-bit serial stream
    task automatic applyStimulus(input logic start, input logic b, input logic v);
        serial_start = start;
        serial_in    = b;
        serial_valid = v;
        tick();
        serial_start = 1'b0;
        serial_valid = 1'b0;
    endtask

    // Send a full 8-bit frame LSB-first; optionally raise m_ready for the final edge
    task automatic sendFrame8(input logic [7:0] w, input logic push, input logic ready_at_last);
        if (push) begin
            exp0.push_back({24'd0, w});
            exp1.push_back({24'd0, rev8(w)});
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && ready_at_last) m_ready = 1'b1;
            applyStimulus(i == 0, w[i], 1'b1);
        end
    endtask

    // Send a 12-bit frame MSB-first to the 12-bit instance
    task automatic sendFrame12(input logic [11:0] w);
        exp2.push_back({20'd0, w});
        for (int i = 11; i >= 0; i--) begin
            serial_start2 = (i == 11);
            serial_in2    = w[i];
            serial_valid2 = 1'b1;
            tick();
        end
        serial_start2 = 1'b0;
        serial_valid2 = 1'b0;
    endtask

    // Scoreboard: pop and compare on every accepted transfer; count status pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid0 && m_ready) begin
                if (exp0.size() == 0) checkOutput("sb0_unexpected", 32'd1, 32'd0);
                else checkOutput("sb0_data", {24'd0, m_data0}, exp0.pop_front());
            end
            if (m_valid1 && m_ready) begin
                if (exp1.size() == 0) checkOutput("sb1_unexpected", 32'd1, 32'd0);
                else checkOutput("sb1_data", {24'd0, m_data1}, exp1.pop_front());
            end
            if (m_valid2 && m_ready2) begin
                if (exp2.size() == 0) checkOutput("sb2_unexpected", 32'd1, 32'd0);
                else checkOutput("sb2_data", {20'd0, m_data2}, exp2.pop_front());
            end
            if (cend0) n_cend++;
            if (ovf0)  n_ovf++;
            if (frs0)  n_frs++;
        end
    end

    initial begin
        rst = 1'b1;
        serial_start = 1'b0; serial_in = 1'b0; serial_valid = 1'b0; abort = 1'b0; m_ready = 1'b1;
        serial_start2 = 1'b0; serial_in2 = 1'b0; serial_valid2 = 1'b0; abort2 = 1'b0; m_ready2 = 1'b1;
        tick();
        tick();
        checkOutput("rst_m_valid", {31'd0, m_valid0}, 32'd0);
        checkOutput("rst_m_data", {24'd0, m_data0}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy0}, 32'd0);
        checkOutput("rst_pulses", {29'd0, cend0, ovf0, frs0}, 32'd0);
        rst = 1'b0;
        tick();

        // Basic LSB-first / MSB-first frame with immediate acceptance
        sendFrame8(8'h4D, 1'b1, 1'b0);
        checkOutput("t1_data0", {24'd0, m_data0}, 32'h4D);
        checkOutput("t1_data1", {24'd0, m_data1}, 32'hB2);
        checkOutput("t1_valid", {31'd0, m_valid0}, 32'd1);
        checkOutput("t1_cend", {31'd0, cend0}, 32'd1);
        checkOutput("t1_busy", {31'd0, busy0}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_valid_drop", {31'd0, m_valid0}, 32'd0);
        checkOutput("t1_cend_drop", {31'd0, cend0}, 32'd0);

        // 12-bit MSB-first frame
        sendFrame12(12'hA5C);
        checkOutput("t2_data12", {20'd0, m_data2}, 32'hA5C);
        checkOutput("t2_cend12", {31'd0, cend2}, 32'd1);
        tick();

        // Gaps with toggling data and an unqualified start
        exp0.push_back(32'h4D);
        exp1.push_back({24'd0, rev8(8'h4D)});
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i == 0, snap_bit(8'h4D, i), 1'b1);
            if (i == 2 || i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(g == 1, ~snap_bit(8'h4D, i), 1'b0);
                    checkOutput("t3_busy_gap", {31'd0, busy0}, 32'd1);
                end
            end
        end
        checkOutput("t3_data", {24'd0, m_data0}, 32'h4D);
        checkOutput("t3_valid", {31'd0, m_valid0}, 32'd1);
        tick();

        // Backpressure, overflow, and drain on the exact completion edge
        m_ready = 1'b0;
        snap = n_ovf;
        sendFrame8(8'h4D, 1'b1, 1'b0);
        sendFrame8(8'h3C, 1'b0, 1'b0);
        checkOutput("t4_ovf_pulse", {31'd0, ovf0}, 32'd1);
        checkOutput("t4_held_data", {24'd0, m_data0}, 32'h4D);
        checkOutput("t4_held_valid", {31'd0, m_valid0}, 32'd1);
        sendFrame8(8'h81, 1'b1, 1'b1);
        checkOutput("t4_new_data", {24'd0, m_data0}, 32'h81);
        checkOutput("t4_new_valid", {31'd0, m_valid0}, 32'd1);
        checkOutput("t4_no_ovf", {31'd0, ovf0}, 32'd0);
        checkOutput("t4_cend", {31'd0, cend0}, 32'd1);
        tick();
        checkOutput("t4_ovf_count", n_ovf - snap, 32'd1);

        // Restart mid-frame
        snap = n_frs;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        sendFrame8(8'h4D, 1'b1, 1'b0);
        checkOutput("t5_restart_data", {24'd0, m_data0}, 32'h4D);
        tick();
        checkOutput("t5_frs_count", n_frs - snap, 32'd1);

        // Abort with a word held in the output register
        m_ready = 1'b0;
        sendFrame8(8'h3C, 1'b1, 1'b0);
        tick();
        snap = n_cend;
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        abort = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        abort = 1'b0;
        checkOutput("t5_abort_busy", {31'd0, busy0}, 32'd0);
        checkOutput("t5_abort_valid", {31'd0, m_valid0}, 32'd1);
        checkOutput("t5_abort_data", {24'd0, m_data0}, 32'h3C);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t5_idle_busy", {31'd0, busy0}, 32'd0);
        checkOutput("t5_no_cend", n_cend - snap, 32'd0);
        m_ready = 1'b1;
        tick();
        tick();

        // Reset mid-frame with a held word
        m_ready = 1'b0;
        sendFrame8(8'h5A, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        exp0.delete();
        exp1.delete();
        tick();
        rst = 1'b0;
        checkOutput("t6_valid", {31'd0, m_valid0}, 32'd0);
        checkOutput("t6_data", {24'd0, m_data0}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy0}, 32'd0);
        checkOutput("t6_pulses", {29'd0, cend0, ovf0, frs0}, 32'd0);
        m_ready = 1'b1;
        tick();
        sendFrame8(8'h4D, 1'b1, 1'b0);
        checkOutput("t6_after_data", {24'd0, m_data0}, 32'h4D);
        checkOutput("t6_after_cend", {31'd0, cend0}, 32'd1);
        tick();
        tick();

        checkOutput("drain0", exp0.size(), 32'd0);
        checkOutput("drain1", exp1.size(), 32'd0);
        checkOutput("drain2", exp2.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic snap_bit(input logic [7:0] w, input int i);
        return w[i];
    endfunction

endmodule
